// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared states, opcodes and default widths for the ALU op sequencer.
// Revision: 1.0
`default_nettype none

package alu_seq_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int SEL_W_DEF = 3;

  localparam logic [SEL_W_DEF-1:0] OP_ADD = 3'd0;
  localparam logic [SEL_W_DEF-1:0] OP_SUB = 3'd1;
  localparam logic [SEL_W_DEF-1:0] OP_AND = 3'd2;
  localparam logic [SEL_W_DEF-1:0] OP_OR  = 3'd3;
  localparam logic [SEL_W_DEF-1:0] OP_XOR = 3'd4;
  localparam logic [SEL_W_DEF-1:0] OP_MUL = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    OUTPUT  = 3'd3,
    FINISH  = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_ref_model.sv
// alu_ref_model: combinational expected result of the ALU, all ops modulo 2^OUT_W.
// Revision: 1.0
`default_nettype none

module alu_ref_model
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int OUT_W = WIDTH + 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_W-1:0] expected
);

  logic [OUT_W-1:0] a_x;
  logic [OUT_W-1:0] b_x;

  always_comb begin
    a_x      = OUT_W'(a);
    b_x      = OUT_W'(b);
    expected = '0;
    case (sel)
      OP_ADD:  expected = a_x + b_x;
      OP_SUB:  expected = a_x - b_x;
      OP_AND:  expected = a_x & b_x;
      OP_OR:   expected = a_x | b_x;
      OP_XOR:  expected = a_x ^ b_x;
      OP_MUL:  expected = a_x * b_x;
      default: expected = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives one operand pair through opcodes 0..NUM_OPS-1 and streams results.
// Optional result checker enabled by ALU_SEQ_CHECK_EN. Revision: 1.0
`default_nettype none

module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int NUM_OPS = 6,
  parameter int OUT_W   = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [OUT_W-1:0] alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SEL_W-1:0] res_sel,
  output logic [OUT_W-1:0] res_data
`ifdef ALU_SEQ_CHECK_EN
  ,
  output logic             mismatch,
  output logic [7:0]       err_count
`endif
);

  localparam logic [SEL_W-1:0] LAST_OP = SEL_W'(NUM_OPS - 1);

  state_t           state;
  state_t           state_nx;
  logic [SEL_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    done     = (state == FINISH);
    case (state)
      IDLE:    if (start) state_nx = ISSUE;
      ISSUE:   state_nx = CAPTURE;
      CAPTURE: state_nx = OUTPUT;
      OUTPUT:  if (res_ready) state_nx = (cnt == LAST_OP) ? FINISH : ISSUE;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_sel   <= '0;
      res_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            alu_a <= op_a;
            alu_b <= op_b;
            cnt   <= '0;
          end
        end
        ISSUE: alu_sel <= cnt;
        CAPTURE: begin
          res_data  <= alu_out;
          res_sel   <= alu_sel;
          res_valid <= 1'b1;
        end
        OUTPUT: begin
          // Counter stops at the last op so it never wraps past NUM_OPS-1.
          if (res_ready) begin
            res_valid <= 1'b0;
            if (cnt != LAST_OP) cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_CHECK_EN
  logic [OUT_W-1:0] expected;

  alu_ref_model #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W),
    .OUT_W (OUT_W)
  ) u_ref (
    .a        (alu_a),
    .b        (alu_b),
    .sel      (alu_sel),
    .expected (expected)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) err_count <= '0;
        CAPTURE: begin
          mismatch <= (alu_out != expected);
          if ((alu_out != expected) && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
        OUTPUT: if (res_ready) mismatch <= 1'b0;
        default: ;
      endcase
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed vector bench for alu_op_sequencer with a behavioural ALU.
// Revision: 1.0
`default_nettype none

module tb_alu_op_sequencer;

  typedef struct packed {
    logic [3:0]      a;
    logic [3:0]      b;
    logic [5:0][4:0] exp_res;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] op_a = '0;
  logic [3:0] op_b = '0;
  logic       busy;
  logic       done;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [4:0] alu_out;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [2:0] res_sel;
  logic [4:0] res_data;
`ifdef ALU_SEQ_CHECK_EN
  logic       mismatch;
  logic [7:0] err_count;
`endif

  logic       force_zero = 1'b0;
  logic [4:0] ax;
  logic [4:0] bx;

  int n_checks = 0;
  int n_fail = 0;

  vec_t       vecs [4];
  logic [2:0] hs_sel  [16];
  logic [4:0] hs_data [16];
  logic       hs_mm   [16];
  int         n_hs;
  int         busy_cycles;
  int         dones;
  int         first_valid;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sel   (res_sel),
    .res_data  (res_data)
`ifdef ALU_SEQ_CHECK_EN
    ,
    .mismatch  (mismatch),
    .err_count (err_count)
`endif
  );

  // Stand-in for the external combinational ALU; force_zero corrupts op 0.
  always_comb begin
    ax = {1'b0, alu_a};
    bx = {1'b0, alu_b};
    alu_out = '0;
    case (alu_sel)
      3'd0: alu_out = ax + bx;
      3'd1: alu_out = ax - bx;
      3'd2: alu_out = ax & bx;
      3'd3: alu_out = ax | bx;
      3'd4: alu_out = ax ^ bx;
      3'd5: alu_out = ax * bx;
      default: alu_out = '0;
    endcase
    if (force_zero && alu_sel == 3'd0) alu_out = '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input logic [3:0] a, input logic [3:0] b, input int stall_sel,
                     input int stall_n, input bit poke);
    int         stall_left;
    bit         timed_out;
    logic [4:0] stall_first;
    stall_left  = stall_n;
    timed_out   = 1'b1;
    stall_first = '0;
    n_hs = 0; busy_cycles = 0; dones = 0; first_valid = -1;
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1; res_ready = 1'b1;
    for (int it = 1; it <= 300; it++) begin
      @(negedge clk);
      start = 1'b0; op_a = a; op_b = b;
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
      busy_cycles++;
      if (done) dones++;
      if (res_valid && first_valid < 0) first_valid = it;
      if (poke && (it == 5 || done)) begin
        start = 1'b1; op_a = ~a; op_b = ~b;
      end
      if (res_valid && int'(res_sel) == stall_sel && stall_left > 0) begin
        if (stall_left == stall_n) stall_first = res_data;
        res_ready = 1'b0;
        stall_left--;
        check("stall_valid", res_valid, 1);
        check("stall_sel", res_sel, stall_sel);
        check("stall_data", res_data, stall_first);
      end else begin
        res_ready = 1'b1;
      end
      if (res_valid && res_ready && n_hs < 16) begin
        hs_sel[n_hs]  = res_sel;
        hs_data[n_hs] = res_data;
`ifdef ALU_SEQ_CHECK_EN
        hs_mm[n_hs]   = mismatch;
`else
        hs_mm[n_hs]   = 1'b0;
`endif
        n_hs++;
      end
    end
    if (timed_out) check("run_timeout", 1, 0);
  endtask

  task automatic check_run(input int v, input int exp_busy);
    check("handshake_count", n_hs, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("res_sel_op%0d", i), hs_sel[i], i);
      check($sformatf("res_data_op%0d", i), hs_data[i], vecs[v].exp_res[i]);
    end
    check("busy_cycles", busy_cycles, exp_busy);
    check("done_pulses", dones, 1);
    check("first_valid_latency", first_valid, 3);
    check("alu_a_hold", alu_a, vecs[v].a);
    check("alu_b_hold", alu_b, vecs[v].b);
    check("alu_sel_hold", alu_sel, 5);
  endtask

  initial begin
    bit found;
    // exp_res listed mul, xor, or, and, sub, add (element 0 is add)
    vecs[0] = '{a: 4'b1010, b: 4'b0101, exp_res: {5'd18, 5'd15, 5'd15, 5'd0,  5'd5,  5'd15}};
    vecs[1] = '{a: 4'b0011, b: 4'b0101, exp_res: {5'd15, 5'd6,  5'd7,  5'd1,  5'd30, 5'd8}};
    vecs[2] = '{a: 4'b1111, b: 4'b1111, exp_res: {5'd1,  5'd0,  5'd15, 5'd15, 5'd0,  5'd30}};
    vecs[3] = '{a: 4'b0000, b: 4'b0001, exp_res: {5'd0,  5'd1,  5'd1,  5'd0,  5'd31, 5'd1}};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_sel", res_sel, 0);
    check("rst_res_data", res_data, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 4; v++) begin
      run(vecs[v].a, vecs[v].b, -1, 0, 1'b0);
      check_run(v, 19);
`ifdef ALU_SEQ_CHECK_EN
      check("err_count_clean", err_count, 0);
`endif
    end

    // Backpressure on op 2 for five cycles.
    run(vecs[0].a, vecs[0].b, 2, 5, 1'b0);
    check_run(0, 24);

    // start pulses mid-run and in FINISH must be ignored.
    run(vecs[1].a, vecs[1].b, -1, 0, 1'b1);
    check_run(1, 19);
    repeat (3) @(negedge clk);
    check("poke_idle_busy", busy, 0);
    check("poke_idle_done", done, 0);
    check("poke_idle_alu_a", alu_a, vecs[1].a);

    // Asynchronous reset during CAPTURE of op 3.
    @(negedge clk);
    op_a = vecs[0].a; op_b = vecs[0].b; start = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int it = 0; it < 50; it++) begin
      if (alu_sel == 3'd3 && !res_valid && busy) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_capture_op3", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_alu_a", alu_a, 0);
    check("arst_alu_b", alu_b, 0);
    check("arst_alu_sel", alu_sel, 0);
    check("arst_res_valid", res_valid, 0);
    check("arst_res_sel", res_sel, 0);
    check("arst_res_data", res_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int it = 0; it < 4; it++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("arst_no_done", dones, 0);
    check("arst_idle_busy", busy, 0);
    run(vecs[0].a, vecs[0].b, -1, 0, 1'b0);
    check_run(0, 19);

`ifdef ALU_SEQ_CHECK_EN
    force_zero = 1'b1;
    run(vecs[0].a, vecs[0].b, -1, 0, 1'b0);
    force_zero = 1'b0;
    check("chk_forced_data", hs_data[0], 0);
    check("chk_mismatch_op0", hs_mm[0], 1);
    check("chk_mismatch_op1", hs_mm[1], 0);
    check("chk_mismatch_op5", hs_mm[5], 0);
    check("chk_err_count_end", err_count, 1);
    @(negedge clk);
    op_a = vecs[2].a; op_b = vecs[2].b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("chk_err_count_cleared", err_count, 0);
    found = 1'b0;
    for (int it = 0; it < 100; it++) begin
      @(negedge clk);
      if (!busy) begin
        found = 1'b1;
        break;
      end
    end
    check("chk_run_finished", found, 1);
    check("chk_err_count_clean_run", err_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
